// File: rtl/drain_counter_if.sv
// -----------------------------------------------------------------------------
// drain_counter_if
//
// Bundles the data and handshake signals around drain_counter:
//   - D0/D1 FIFO read side : empty_d0/d1, data_d0/d1 (in), pop_d0/d1 (out)
//   - merged output stream : out_data, out_dest, out_valid (out)
//   - counter read port    : req, req_idx (in), count_out, count_valid (out)
//
// Modports:
//   master : the drain_counter itself (drives pops, stream and count reply)
//   slave  : the environment (FIFOs, stream sink, counter reader)
// -----------------------------------------------------------------------------
interface drain_counter_if #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 5
);

  // FIFO read side
  logic              empty_d0;
  logic              empty_d1;
  logic [DATA_W-1:0] data_d0;
  logic [DATA_W-1:0] data_d1;
  logic              pop_d0;
  logic              pop_d1;

  // Merged output stream
  logic [DATA_W-1:0] out_data;
  logic              out_dest;
  logic              out_valid;

  // Counter read port
  logic              req;
  logic              req_idx;
  logic [CNT_W-1:0]  count_out;
  logic              count_valid;

  modport master (
    input  empty_d0, empty_d1, data_d0, data_d1, req, req_idx,
    output pop_d0, pop_d1, out_data, out_dest, out_valid, count_out, count_valid
  );

  modport slave (
    output empty_d0, empty_d1, data_d0, data_d1, req, req_idx,
    input  pop_d0, pop_d1, out_data, out_dest, out_valid, count_out, count_valid
  );

endinterface

// File: rtl/drain_counter.sv
// -----------------------------------------------------------------------------
// drain_counter
//
// Drains the two destination FIFOs (D0, D1) in round-robin order and merges
// their words into one registered output stream tagged with the source. Keeps
// a saturating word count per destination, readable through a one-shot
// request/response port while the transaction layer is idle.
//
// Ports:
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   init       : synchronous clear of counters, arbiter and in-flight tracking
//   active_in  : popping allowed only while 1
//   idle_in    : counter reads are served only while 1
//   error_in   : freezes draining
//   bus        : drain_counter_if.master (FIFO side, output stream, count port)
//
// Pipeline: pop in cycle N -> FIFO data valid in N+1 -> out_* registered,
// visible in N+2. Counters update on the same edge that raises out_valid.
// -----------------------------------------------------------------------------
module drain_counter #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  input  logic           active_in,
  input  logic           idle_in,
  input  logic           error_in,
  drain_counter_if.master bus
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q,       state_d;
  logic              grant_q,       grant_d;      // 0 = D0 has priority
  logic              pend_q,        pend_d;       // pop issued last cycle
  logic              pend_sel_q,    pend_sel_d;   // which FIFO was popped
  logic              idx_q,         idx_d;        // counter selected for REPORT
  logic [CNT_W-1:0]  cnt_d0_q,      cnt_d0_d;
  logic [CNT_W-1:0]  cnt_d1_q,      cnt_d1_d;
  logic [DATA_W-1:0] out_data_q,    out_data_d;
  logic              out_dest_q,    out_dest_d;
  logic              out_valid_q,   out_valid_d;
  logic [CNT_W-1:0]  count_out_q,   count_out_d;
  logic              count_valid_q, count_valid_d;

  // ---------------------------------------------------------------------------
  // Arbitration and pop strobes
  // ---------------------------------------------------------------------------
  logic run_ok;     // draining permitted this cycle
  logic sel;        // effective grant after skipping an empty FIFO
  logic pop_d0;
  logic pop_d1;
  logic any_pop;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    run_ok = active_in & ~error_in & ~init;

    // The registered grant only expresses priority: when the preferred FIFO
    // is empty the other one is taken, which keeps one word per cycle flowing
    // while only a single FIFO holds data.
    sel = grant_q;
    if (grant_q == 1'b0) begin
      sel = bus.empty_d0 ? 1'b1 : 1'b0;
    end else begin
      sel = bus.empty_d1 ? 1'b0 : 1'b1;
    end

    // Pops are suppressed in the very cycle active_in drops, error_in rises
    // or init is asserted, so nothing is pulled that cannot be tracked.
    pop_d0  = (state_q == ST_RUN) & run_ok & ~sel & ~bus.empty_d0;
    pop_d1  = (state_q == ST_RUN) & run_ok &  sel & ~bus.empty_d1;
    any_pop = pop_d0 | pop_d1;
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        // A pending read is served before draining resumes; REPORT then
        // returns straight to RUN if the layer is still active.
        if (bus.req && idle_in) begin
          state_d = ST_REPORT;
        end else if (active_in && !error_in) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!active_in || error_in) begin
          state_d = ST_IDLE;
        end else if (bus.req && idle_in && !any_pop) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        state_d = (active_in && !error_in) ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (init) begin
      state_d = ST_IDLE;
    end

    // Latch the counter index only on entry; requests outside the entry
    // condition are dropped rather than queued.
    if ((state_d == ST_REPORT) && (state_q != ST_REPORT)) begin
      idx_d = bus.req_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant, in-flight tracking and output stream
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_d    = grant_q;
    pend_d     = any_pop;
    pend_sel_d = pend_sel_q;
    out_valid_d = pend_q;
    out_data_d  = out_data_q;
    out_dest_d  = out_dest_q;

    // After a pop the other FIFO gets priority.
    if (any_pop) begin
      grant_d    = pop_d0;
      pend_sel_d = pop_d1;
    end

    // The FIFO read data is valid exactly one cycle after the pop.
    if (pend_q) begin
      out_data_d = pend_sel_q ? bus.data_d1 : bus.data_d0;
      out_dest_d = pend_sel_q;
    end

    // init clears the arbiter; a word already captured in pend_q is still
    // emitted above because out_*_d does not depend on init.
    if (init) begin
      grant_d = 1'b0;
      pend_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating counters and count report
  // ---------------------------------------------------------------------------
  logic inc_d0;
  logic inc_d1;

  always_comb begin
    // Counting on the same edge that raises out_valid means a word emitted
    // in the cycle after init is never counted.
    inc_d0 = pend_q & ~pend_sel_q;
    inc_d1 = pend_q &  pend_sel_q;

    cnt_d0_d = cnt_d0_q;
    cnt_d1_d = cnt_d1_q;
    if (inc_d0 && (cnt_d0_q != CNT_MAX)) begin
      cnt_d0_d = cnt_d0_q + CNT_W'(1);
    end
    if (inc_d1 && (cnt_d1_q != CNT_MAX)) begin
      cnt_d1_d = cnt_d1_q + CNT_W'(1);
    end
    if (init) begin
      cnt_d0_d = '0;
      cnt_d1_d = '0;
    end

    // The reported value uses the next-state counter so an increment landing
    // in the REPORT cycle itself is included.
    count_valid_d = 1'b0;
    count_out_d   = count_out_q;
    if ((state_q == ST_REPORT) && !init) begin
      count_valid_d = 1'b1;
      count_out_d   = idx_q ? cnt_d1_d : cnt_d0_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here, so every flop samples the values
  // that were settled before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      pend_q        <= 1'b0;
      pend_sel_q    <= 1'b0;
      idx_q         <= 1'b0;
      cnt_d0_q      <= '0;
      cnt_d1_q      <= '0;
      out_data_q    <= '0;
      out_dest_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      pend_q        <= pend_d;
      pend_sel_q    <= pend_sel_d;
      idx_q         <= idx_d;
      cnt_d0_q      <= cnt_d0_d;
      cnt_d1_q      <= cnt_d1_d;
      out_data_q    <= out_data_d;
      out_dest_q    <= out_dest_d;
      out_valid_q   <= out_valid_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pop_d0      = pop_d0;
  assign bus.pop_d1      = pop_d1;
  assign bus.out_data    = out_data_q;
  assign bus.out_dest    = out_dest_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.count_out   = count_out_q;
  assign bus.count_valid = count_valid_q;

endmodule
